// File: rtl/program_store_if.sv
//------------------------------------------------------------------------------
// Module   : program_store_if
// Purpose  : Host load/write port of the program store (load control,
//            valid/ready write channel, sticky error flag).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface program_store_if #(
    parameter int DATA_W = 32
) ();
    logic              load_req;
    logic              load_done;
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_sel;
    logic [7:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_err;

    modport master (
        output load_req, load_done, wr_valid, wr_sel, wr_addr, wr_data,
        input  wr_ready, wr_err
    );

    modport slave (
        input  load_req, load_done, wr_valid, wr_sel, wr_addr, wr_data,
        output wr_ready, wr_err
    );
endinterface

`default_nettype wire

// File: rtl/program_store.sv
//------------------------------------------------------------------------------
// Module   : program_store
// Purpose  : Host-writable instruction/delay memory for the glitch sequencer,
//            with registered reads gated to HALT while contents are invalid.
//            Optional macro PROGRAM_STORE_CHECKSUM_EN adds a download checksum.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module program_store #(
    parameter int PROG_DEPTH = 64,
    parameter int INSTR_W    = 12,
    parameter int NUM_DELAYS = 16,
    parameter int DELAY_W    = 32,
    parameter int DATA_W     = 32
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [7:0]         instr_pt,
    input  wire logic [7:0]         delay_num,
    output logic      [INSTR_W-1:0] instr,
    output logic      [INSTR_W-1:0] next_instr,
    output logic      [DELAY_W-1:0] delay_len,
    output logic                    run,
`ifdef PROGRAM_STORE_CHECKSUM_EN
    output logic      [15:0]        prog_csum,
`endif
    program_store_if.slave          host
);

    // Arrays are sized to a power of two so index slices match exactly;
    // entries beyond the configured depth are never read or written.
    localparam int PA_W    = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
    localparam int DA_W    = (NUM_DELAYS > 1) ? $clog2(NUM_DELAYS) : 1;
    localparam int CLR_MAX = (PROG_DEPTH > NUM_DELAYS) ? PROG_DEPTH : NUM_DELAYS;

    localparam logic [8:0]         PROG_LIM   = 9'(PROG_DEPTH);
    localparam logic [8:0]         DLY_LIM    = 9'(NUM_DELAYS);
    localparam logic [7:0]         CLR_LAST   = 8'(CLR_MAX - 1);
    localparam logic [INSTR_W-1:0] HALT_WORD  = '1;
    localparam logic [DELAY_W-1:0] HALT_DELAY = '1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t             r_state;
    logic [7:0]         r_clr;
    logic               r_wr_ready;
    logic               r_wr_err;
    logic [INSTR_W-1:0] r_prog  [0:(1<<PA_W)-1];
    logic [DELAY_W-1:0] r_delay [0:(1<<DA_W)-1];

    logic [DATA_W-1:0]  w_wdata;
    logic [8:0]         w_next_pt;
    logic               w_pt_ok;
    logic               w_next_ok;
    logic               w_dly_ok;
    logic               w_accept;
    logic               w_addr_ok;

    assign w_wdata   = host.wr_data;
    assign w_next_pt = {1'b0, instr_pt} + 9'd1;
    assign w_pt_ok   = {1'b0, instr_pt} < PROG_LIM;
    assign w_next_ok = w_next_pt < PROG_LIM;
    assign w_dly_ok  = {1'b0, delay_num} < DLY_LIM;
    assign w_accept  = host.wr_valid & r_wr_ready;
    assign w_addr_ok = host.wr_sel ? ({1'b0, host.wr_addr} < DLY_LIM)
                                   : ({1'b0, host.wr_addr} < PROG_LIM);

    assign host.wr_ready = r_wr_ready;
    assign host.wr_err   = r_wr_err;

    // Storage: zeroed one entry per cycle in CLEAR, host writes in LOAD
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                if ({1'b0, r_clr} < PROG_LIM) r_prog[r_clr[PA_W-1:0]]  <= '0;
                if ({1'b0, r_clr} < DLY_LIM)  r_delay[r_clr[DA_W-1:0]] <= '0;
            end else if (w_accept && w_addr_ok) begin
                if (host.wr_sel)
                    r_delay[host.wr_addr[DA_W-1:0]] <= w_wdata[DELAY_W-1:0];
                else
                    r_prog[host.wr_addr[PA_W-1:0]]  <= w_wdata[INSTR_W-1:0];
            end
        end
    end

`ifdef PROGRAM_STORE_CHECKSUM_EN
    logic [31:0] w_d32;
    logic [15:0] r_csum;
    assign w_d32     = 32'(w_wdata);
    assign prog_csum = r_csum;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_CLEAR;
            r_clr      <= '0;
            instr      <= HALT_WORD;
            next_instr <= HALT_WORD;
            delay_len  <= HALT_DELAY;
            run        <= 1'b0;
            r_wr_ready <= 1'b0;
            r_wr_err   <= 1'b0;
`ifdef PROGRAM_STORE_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            instr      <= HALT_WORD;
            next_instr <= HALT_WORD;
            delay_len  <= HALT_DELAY;
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr == CLR_LAST) begin
                        r_state <= ST_RUN;
                        run     <= 1'b1;
                    end else begin
                        r_clr <= r_clr + 8'd1;
                    end
                end
                ST_RUN: begin
                    instr      <= w_pt_ok   ? r_prog[instr_pt[PA_W-1:0]]   : HALT_WORD;
                    next_instr <= w_next_ok ? r_prog[w_next_pt[PA_W-1:0]]  : HALT_WORD;
                    delay_len  <= w_dly_ok  ? r_delay[delay_num[DA_W-1:0]] : HALT_DELAY;
                    if (host.load_req) begin
                        r_state    <= ST_LOAD;
                        run        <= 1'b0;
                        r_wr_ready <= 1'b1;
                        r_wr_err   <= 1'b0;
`ifdef PROGRAM_STORE_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (w_accept && !w_addr_ok)
                        r_wr_err <= 1'b1;
`ifdef PROGRAM_STORE_CHECKSUM_EN
                    if (w_accept && w_addr_ok)
                        r_csum <= r_csum + w_d32[15:0] + w_d32[31:16]
                                + {7'd0, host.wr_sel, host.wr_addr};
`endif
                    // A write presented alongside load_done still lands this edge
                    if (host.load_done) begin
                        r_state    <= ST_RUN;
                        run        <= 1'b1;
                        r_wr_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_clr   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_store.sv
//------------------------------------------------------------------------------
// Module   : tb_program_store
// Purpose  : Self-checking bench for program_store against an array model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_program_store;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  instr_pt  = '0;
    logic [7:0]  delay_num = '0;
    logic [11:0] instr;
    logic [11:0] next_instr;
    logic [31:0] delay_len;
    logic        run;
`ifdef PROGRAM_STORE_CHECKSUM_EN
    logic [15:0] prog_csum;
`endif

    program_store_if #(.DATA_W(32)) host ();

    program_store #(
        .PROG_DEPTH (64),
        .INSTR_W    (12),
        .NUM_DELAYS (16),
        .DELAY_W    (32),
        .DATA_W     (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_pt   (instr_pt),
        .delay_num  (delay_num),
        .instr      (instr),
        .next_instr (next_instr),
        .delay_len  (delay_len),
        .run        (run),
`ifdef PROGRAM_STORE_CHECKSUM_EN
        .prog_csum  (prog_csum),
`endif
        .host       (host)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [11:0] m_prog [64];
    logic [31:0] m_dly  [16];
    logic        m_err;
    logic [15:0] m_csum;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_instr(input int idx);
        return (idx < 64) ? 32'(m_prog[idx]) : 32'h0000_0FFF;
    endfunction

    function automatic logic [31:0] m_delay(input int idx);
        return (idx < 16) ? m_dly[idx] : 32'hFFFF_FFFF;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_prog[i] = '0;
        for (int i = 0; i < 16; i++) m_dly[i]  = '0;
    endtask

    task automatic read_at(input int pt, input int dn);
        instr_pt  = pt[7:0];
        delay_num = dn[7:0];
        tick();
        check("instr",      32'(instr),      m_instr(pt));
        check("next_instr", 32'(next_instr), m_instr(pt + 1));
        check("delay_len",  delay_len,       m_delay(dn));
    endtask

    task automatic wait_run(output int cnt);
        cnt = 0;
        while (!run && cnt < 300) begin
            tick();
            cnt++;
        end
    endtask

    task automatic pulse_load_req();
        host.load_req = 1'b1;
        tick();
        host.load_req = 1'b0;
        m_err  = 1'b0;
        m_csum = '0;
    endtask

    task automatic pulse_load_done();
        host.load_done = 1'b1;
        tick();
        host.load_done = 1'b0;
    endtask

    task automatic model_write(input logic sel, input int addr, input logic [31:0] data);
        if (sel ? (addr < 16) : (addr < 64)) begin
            if (sel) m_dly[addr]  = data;
            else     m_prog[addr] = data[11:0];
            m_csum = m_csum + data[15:0] + data[31:16] + 16'({sel, addr[7:0]});
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic drive_write(input logic sel, input int addr, input logic [31:0] data);
        host.wr_valid = 1'b1;
        host.wr_sel   = sel;
        host.wr_addr  = addr[7:0];
        host.wr_data  = data;
    endtask

    task automatic write(input logic sel, input int addr, input logic [31:0] data);
        drive_write(sel, addr, data);
        tick();
        host.wr_valid = 1'b0;
        model_write(sel, addr, data);
    endtask

    initial begin
        int          cnt;
        logic        sel;
        int          addr;
        logic [31:0] data;

        host.load_req  = 1'b0;
        host.load_done = 1'b0;
        host.wr_valid  = 1'b0;
        host.wr_sel    = 1'b0;
        host.wr_addr   = '0;
        host.wr_data   = '0;
        m_err  = 1'b0;
        m_csum = '0;
        model_clear();

        // Reset state
        tick();
        tick();
        check("rst_run",      32'(run),          32'd0);
        check("rst_instr",    32'(instr),        32'h0000_0FFF);
        check("rst_next",     32'(next_instr),   32'h0000_0FFF);
        check("rst_delay",    delay_len,         32'hFFFF_FFFF);
        check("rst_wr_ready", 32'(host.wr_ready), 32'd0);
        check("rst_wr_err",   32'(host.wr_err),   32'd0);

        // CLEAR lasts exactly max(depths) cycles
        reset = 1'b0;
        wait_run(cnt);
        check("clear_cycles", 32'(cnt), 32'd64);
        read_at(0, 0);

        // First download: random writes (some out of range), then directed ones
        pulse_load_req();
        check("load_run",      32'(run),           32'd0);
        check("load_wr_ready", 32'(host.wr_ready), 32'd1);
        for (int i = 0; i < 24; i++) begin
            sel  = 1'($urandom_range(0, 1));
            addr = sel ? int'($urandom_range(0, 19)) : int'($urandom_range(0, 70));
            data = $urandom;
            write(sel, addr, data);
        end
        check("load_halt_instr", 32'(instr), 32'h0000_0FFF);
        check("load_halt_delay", delay_len,  32'hFFFF_FFFF);
        write(1'b0, 0,  32'h0000_090C);
        write(1'b0, 1,  32'h0000_0802);
        write(1'b0, 63, 32'h0000_0ABC);
        write(1'b1, 3,  32'h0402_EAA0);
        check("load_wr_err", 32'(host.wr_err), 32'(m_err));
        pulse_load_done();
        check("done_run",       32'(run),   32'd1);
        check("done_halt_instr", 32'(instr), 32'h0000_0FFF);
        read_at(0, 3);
        check("plan_instr0", 32'(instr),      32'h0000_090C);
        check("plan_next0",  32'(next_instr), 32'h0000_0802);
        check("plan_delay3", delay_len,       32'h0402_EAA0);
        read_at(63, 16);
        read_at(200, 15);
        read_at(255, 255);
        for (int i = 0; i < 30; i++)
            read_at(int'($urandom_range(0, 70)), int'($urandom_range(0, 20)));

        // Out-of-range write and sticky error
        pulse_load_req();
        check("err_cleared", 32'(host.wr_err), 32'd0);
        write(1'b0, 64, 32'h0000_0777);
        check("err_set", 32'(host.wr_err), 32'd1);
        host.load_req = 1'b1;
        tick();
        host.load_req = 1'b0;
        check("err_sticky", 32'(host.wr_err), 32'd1);
        check("err_in_load", 32'(run), 32'd0);
        pulse_load_done();
        read_at(63, 0);
        for (int i = 0; i < 10; i++)
            read_at(int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
        pulse_load_req();
        check("err_recleared", 32'(host.wr_err), 32'd0);

        // Write together with load_done
        drive_write(1'b0, 5, 32'h0000_0123);
        host.load_done = 1'b1;
        tick();
        host.wr_valid  = 1'b0;
        host.load_done = 1'b0;
        model_write(1'b0, 5, 32'h0000_0123);
        check("same_cycle_run", 32'(run), 32'd1);
        read_at(5, 3);
        read_at(4, 0);

        // Reset in the middle of LOAD re-zeroes everything
        pulse_load_req();
        write(1'b0, 7, 32'h0000_0555);
        write(1'b1, 2, 32'h1234_5678);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midload_run", 32'(run), 32'd0);
        wait_run(cnt);
        check("midload_clear_cycles", 32'(cnt), 32'd64);
        model_clear();
        for (int i = 0; i < 64; i++)
            read_at(i, i % 17);

        // Reset in the middle of CLEAR restarts the count
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_run(cnt);
        check("midclear_cycles", 32'(cnt), 32'd64);
        read_at(7, 2);

`ifdef PROGRAM_STORE_CHECKSUM_EN
        pulse_load_req();
        check("csum_cleared", 32'(prog_csum), 32'd0);
        write(1'b0, 1, 32'h0000_0005);
        check("csum_plan", 32'(prog_csum), 32'h0000_0006);
        write(1'b1, 9, $urandom);
        write(1'b0, 80, $urandom);
        check("csum_model", 32'(prog_csum), 32'(m_csum));
        pulse_load_done();
        tick();
        check("csum_held", 32'(prog_csum), 32'(m_csum));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/program_store.md
Name: program_store

Overview:
- Parametrised, host-writable program and delay memory for the glitch sequencer; successor to the fixed-content program ROM.
- Holds the instruction words and the delay table, and is loaded at run time through a valid/ready write port, e.g. from the UART command path.
- Serves the sequencer with registered instr/next_instr/delay_len reads.
- Gates its outputs to a safe "halt" value whenever its contents are not valid.

Parameters:
- PROG_DEPTH, 64, number of instruction words (2..256)
- INSTR_W, 12, instruction word width
- NUM_DELAYS, 16, number of delay table entries (1..256)
- DELAY_W, 32, delay entry width
- DATA_W, 32, host write data width (must be >= max(INSTR_W, DELAY_W))

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_pt  in  8  instruction pointer from sequencer
- delay_num  in  8  delay table index from sequencer
- instr  out  INSTR_W  word at instr_pt
- next_instr  out  INSTR_W  word at instr_pt+1
- delay_len  out  DELAY_W  delay entry at delay_num
- run  out  1  contents valid; sequencer may execute
- load_req  in  1  pulse: enter LOAD
- load_done  in  1  pulse: leave LOAD, commit
- wr_valid  in  1  host write request
- wr_ready  out  1  write accepted this cycle when wr_valid&wr_ready
- wr_sel  in  1  0 = program, 1 = delay table
- wr_addr  in  8  target index
- wr_data  in  DATA_W  data; low INSTR_W bits used for program writes
- wr_err  out  1  sticky: out-of-range write seen since load_req

Behaviour:
- HALT_WORD is all ones, INSTR_W wide. HALT_DELAY is all ones, DELAY_W wide.
- Reset values: instr=next_instr=HALT_WORD, delay_len=HALT_DELAY, run=0, wr_ready=0, wr_err=0, state=CLEAR, clear counter=0.
- CLEAR:
  - Writes 0 to program[c] for c<PROG_DEPTH and to delay[c] for c<NUM_DELAYS; one entry per cycle per memory.
  - c counts to max(PROG_DEPTH, NUM_DELAYS)-1, then → RUN.
  - load_req is ignored while in CLEAR.
- RUN:
  - run=1, wr_ready=0.
  - Every cycle: instr<=program[instr_pt], next_instr<=program[instr_pt+1], delay_len<=delay[delay_num]. Read latency is 1 cycle.
  - instr_pt+1 is computed 9 bits wide; no wrap.
  - Any index >= PROG_DEPTH reads HALT_WORD; delay_num >= NUM_DELAYS reads HALT_DELAY.
  - load_req → LOAD and clears wr_err.
- LOAD:
  - run=0, wr_ready=1; outputs are forced to HALT_WORD/HALT_DELAY from the next cycle.
  - An accepted write with an in-range address updates the entry on that edge.
  - An out-of-range write is dropped and sets wr_err.
  - load_done → RUN; the first valid read appears the cycle after run rises.
  - load_req while in LOAD is ignored (wr_err is not cleared).
- Same-cycle wr_valid and load_done in LOAD: the write is accepted and committed, then → RUN.
- Reset mid-LOAD or mid-CLEAR: returns to CLEAR, and the memories are re-zeroed.
- Reads never observe partial contents: run is low for the whole of CLEAR and LOAD.

Optional Feature:
- Macro: PROGRAM_STORE_CHECKSUM_EN.
- Defined:
  - Adds output prog_csum [15:0].
  - prog_csum is cleared on reset and on load_req.
  - On each accepted in-range write: csum <= csum + wr_data[15:0] + wr_data[31:16] + {wr_sel, wr_addr}, modulo 2^16.
  - Value is held while in RUN so the host can verify the download.
- Undefined: no port and no logic; all other behaviour is identical.

Test Plan:
- Reset with defaults → run=0 for exactly 64 cycles (CLEAR), then run=1; instr=0, next_instr=0, delay_len=0 for instr_pt=0, delay_num=0.
- load_req; write program[0]=0x90C, program[1]=0x802, delay[3]=0x0402EAA0; load_done → instr_pt=0 gives instr=0x90C and next_instr=0x802 one cycle later; delay_num=3 gives 0x0402EAA0.
- In RUN, instr_pt=63 → instr=program[63], next_instr=0xFFF; instr_pt=200 → both 0xFFF; delay_num=16 → 0xFFFFFFFF.
- In LOAD, write wr_addr=64 with wr_sel=0 → wr_err=1 and no entry changes; next load_req clears wr_err to 0.
- wr_valid together with load_done → the entry is updated and run=1 next cycle; reset asserted mid-LOAD → run=0 and all entries read 0 after CLEAR.
- With PROGRAM_STORE_CHECKSUM_EN: load_req, write wr_sel=0, wr_addr=1, wr_data=0x00000005 → prog_csum=0x0006.
